// File: rtl/memory_s_sp_2048_x_32_arbiter.sv
// rtl/memory_s_sp_2048_x_32_arbiter.sv - round-robin two-port arbiter with byte-write RMW for a 2048x32 SRAM
module memory_s_sp_2048_x_32_arbiter (
   input  logic        sram_clock,
   input  logic        sram_reset_n,
   input  logic        a_req,
   input  logic        a_read_not_write,
   input  logic [10:0] a_address,
   input  logic [31:0] a_write_data,
   input  logic [3:0]  a_byte_enables,
   output logic        a_ack,
   output logic        a_read_data_valid,
   input  logic        b_req,
   input  logic        b_read_not_write,
   input  logic [10:0] b_address,
   input  logic [31:0] b_write_data,
   input  logic [3:0]  b_byte_enables,
   output logic        b_ack,
   output logic        b_read_data_valid,
   output logic [31:0] read_data,
   output logic        sram_read,
   output logic        sram_write,
   output logic [10:0] sram_address,
   output logic [31:0] sram_write_data,
   input  logic [31:0] sram_read_data
);

   typedef enum logic {ST_IDLE, ST_MERGE} state_e;

   state_e      state_q, state_d;
   logic        last_b_q, last_b_d;
   logic        port_b_q, port_b_d;
   logic [10:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [3:0]  be_q, be_d;
   logic        a_rdv_q, a_rdv_d;
   logic        b_rdv_q, b_rdv_d;

   logic        gnt_b;
   logic        g_rnw;
   logic [10:0] g_addr;
   logic [31:0] g_data;
   logic [3:0]  g_be;
   logic        a_ack_c, b_ack_c, rd_c, wr_c;
   logic [10:0] addr_c;
   logic [31:0] wdata_c;

   always_comb begin
      state_d  = state_q;
      last_b_d = last_b_q;
      port_b_d = port_b_q;
      addr_d   = addr_q;
      data_d   = data_q;
      be_d     = be_q;
      a_rdv_d  = 1'b0;
      b_rdv_d  = 1'b0;
      a_ack_c  = 1'b0;
      b_ack_c  = 1'b0;
      rd_c     = 1'b0;
      wr_c     = 1'b0;
      addr_c   = '0;
      wdata_c  = '0;
      // B wins only when A is idle or A was the previous grantee.
      gnt_b    = b_req & (~a_req | ~last_b_q);
      g_rnw    = gnt_b ? b_read_not_write : a_read_not_write;
      g_addr   = gnt_b ? b_address        : a_address;
      g_data   = gnt_b ? b_write_data     : a_write_data;
      g_be     = gnt_b ? b_byte_enables   : a_byte_enables;

      case (state_q)
         ST_IDLE: begin
            if (a_req | b_req) begin
               last_b_d = gnt_b;
               if (g_rnw) begin
                  rd_c    = 1'b1;
                  addr_c  = g_addr;
                  a_ack_c = ~gnt_b;
                  b_ack_c = gnt_b;
                  a_rdv_d = ~gnt_b;
                  b_rdv_d = gnt_b;
               end else if (g_be == 4'hf) begin
                  wr_c    = 1'b1;
                  addr_c  = g_addr;
                  wdata_c = g_data;
                  a_ack_c = ~gnt_b;
                  b_ack_c = gnt_b;
               end else if (g_be == 4'h0) begin
                  a_ack_c = ~gnt_b;
                  b_ack_c = gnt_b;
               end else begin
                  rd_c     = 1'b1;
                  addr_c   = g_addr;
                  port_b_d = gnt_b;
                  addr_d   = g_addr;
                  data_d   = g_data;
                  be_d     = g_be;
                  state_d  = ST_MERGE;
               end
            end
         end
         ST_MERGE: begin
            wr_c   = 1'b1;
            addr_c = addr_q;
            for (int n = 0; n < 4; n++) begin
               wdata_c[8*n +: 8] = be_q[n] ? data_q[8*n +: 8] : sram_read_data[8*n +: 8];
            end
            a_ack_c = ~port_b_q;
            b_ack_c = port_b_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sram_clock or negedge sram_reset_n) begin
      if (!sram_reset_n) begin
         state_q  <= ST_IDLE;
         last_b_q <= 1'b1;
         port_b_q <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         be_q     <= '0;
         a_rdv_q  <= 1'b0;
         b_rdv_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_b_q <= last_b_d;
         port_b_q <= port_b_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         be_q     <= be_d;
         a_rdv_q  <= a_rdv_d;
         b_rdv_q  <= b_rdv_d;
      end
   end

   // Combinational outputs are forced low while reset is held so a pending merge never reaches the SRAM.
   assign a_ack             = sram_reset_n & a_ack_c;
   assign b_ack             = sram_reset_n & b_ack_c;
   assign sram_read         = sram_reset_n & rd_c;
   assign sram_write        = sram_reset_n & wr_c;
   assign sram_address      = sram_reset_n ? addr_c : '0;
   assign sram_write_data   = sram_reset_n ? wdata_c : '0;
   assign read_data         = sram_reset_n ? sram_read_data : '0;
   assign a_read_data_valid = a_rdv_q;
   assign b_read_data_valid = b_rdv_q;

endmodule

// File: tb/tb_memory_s_sp_2048_x_32_arbiter.sv
// tb/tb_memory_s_sp_2048_x_32_arbiter.sv - randomized self-checking bench with word-level memory model
module tb_memory_s_sp_2048_x_32_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_req, a_rnw, b_req, b_rnw;
   logic [10:0] a_addr, b_addr;
   logic [31:0] a_wd, b_wd;
   logic [3:0]  a_be, b_be;
   logic        a_ack, b_ack, a_rdv, b_rdv;
   logic [31:0] read_data;
   logic        sram_read, sram_write;
   logic [10:0] sram_address;
   logic [31:0] sram_write_data;
   logic [31:0] sram_read_data;

   always #5 clk = ~clk;

   memory_s_sp_2048_x_32_arbiter dut (
      .sram_clock(clk), .sram_reset_n(rst_n),
      .a_req(a_req), .a_read_not_write(a_rnw), .a_address(a_addr),
      .a_write_data(a_wd), .a_byte_enables(a_be), .a_ack(a_ack), .a_read_data_valid(a_rdv),
      .b_req(b_req), .b_read_not_write(b_rnw), .b_address(b_addr),
      .b_write_data(b_wd), .b_byte_enables(b_be), .b_ack(b_ack), .b_read_data_valid(b_rdv),
      .read_data(read_data), .sram_read(sram_read), .sram_write(sram_write),
      .sram_address(sram_address), .sram_write_data(sram_write_data),
      .sram_read_data(sram_read_data)
   );

   // SRAM macro stand-in
   logic [31:0] sram_mem [2048];
   always @(posedge clk) begin
      if (sram_write) sram_mem[sram_address] <= sram_write_data;
      if (sram_read)  sram_read_data <= sram_mem[sram_address];
   end

   // Reference: what each word should hold after every acknowledged command
   logic [31:0] ref_mem [2048];
   int n_cmp = 0, n_bad = 0;
   logic        exp_a_rdv = 0, exp_b_rdv = 0;
   logic [31:0] exp_a_data = 0, exp_b_data = 0;
   logic        a_ack_s, b_ack_s, rd_s, wr_s;
   logic [10:0] addr_s;
   logic [31:0] wd_s, rdata_s;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
      logic [31:0] r = old;
      for (int n = 0; n < 4; n++) if (be[n]) r[8*n +: 8] = nw[8*n +: 8];
      return r;
   endfunction

   task automatic step();
      logic nxa, nxb;
      logic [31:0] nda, ndb;
      nxa = 0; nxb = 0; nda = 0; ndb = 0;
      @(negedge clk);
      chk("a_rdv", a_rdv, exp_a_rdv);
      if (exp_a_rdv) chk("a_rdata", read_data, exp_a_data);
      chk("b_rdv", b_rdv, exp_b_rdv);
      if (exp_b_rdv) chk("b_rdata", read_data, exp_b_data);
      chk("strobe_excl", sram_read & sram_write, 0);
      chk("dual_ack", a_ack & b_ack, 0);
      if (a_ack) begin
         chk("a_ack_req", a_req, 1);
         if (a_rnw) begin nxa = 1; nda = ref_mem[a_addr]; end
         else ref_mem[a_addr] = merge(ref_mem[a_addr], a_wd, a_be);
      end
      if (b_ack) begin
         chk("b_ack_req", b_req, 1);
         if (b_rnw) begin nxb = 1; ndb = ref_mem[b_addr]; end
         else ref_mem[b_addr] = merge(ref_mem[b_addr], b_wd, b_be);
      end
      exp_a_rdv = nxa; exp_a_data = nda;
      exp_b_rdv = nxb; exp_b_data = ndb;
      a_ack_s = a_ack; b_ack_s = b_ack; rd_s = sram_read; wr_s = sram_write;
      addr_s = sram_address; wd_s = sram_write_data; rdata_s = read_data;
      @(posedge clk); #1;
   endtask

   task automatic set_a(input logic req, input logic rnw, input logic [10:0] ad, input logic [31:0] d, input logic [3:0] be);
      a_req = req; a_rnw = rnw; a_addr = ad; a_wd = d; a_be = be;
   endtask

   task automatic set_b(input logic req, input logic rnw, input logic [10:0] ad, input logic [31:0] d, input logic [3:0] be);
      b_req = req; b_rnw = rnw; b_addr = ad; b_wd = d; b_be = be;
   endtask

   function automatic logic [3:0] rand_be();
      case ($urandom_range(3, 0))
         0: return 4'hf;
         1: return 4'h0;
         default: return 4'($urandom);
      endcase
   endfunction

   initial begin
      int wait_a, wait_b, max_a, max_b;
      logic pend_a, pend_b;
      for (int i = 0; i < 2048; i++) begin sram_mem[i] = 0; ref_mem[i] = 0; end
      sram_read_data = 0;
      rst_n = 0;
      set_a(1, 1, 11'h3, 0, 4'hf);
      set_b(1, 1, 11'h4, 0, 4'hf);
      #1;
      step();
      chk("rst_a_ack", a_ack_s, 0);
      chk("rst_b_ack", b_ack_s, 0);
      chk("rst_sram_read", rd_s, 0);
      chk("rst_sram_write", wr_s, 0);
      chk("rst_a_rdv", a_rdv, 0);
      set_a(0, 1, 0, 0, 0); set_b(0, 1, 0, 0, 0);
      rst_n = 1;
      step();

      // full write then read back
      set_a(1, 0, 11'h005, 32'h12345678, 4'hf); step();
      chk("t1_wack", a_ack_s, 1); chk("t1_wstrobe", wr_s, 1); chk("t1_waddr", addr_s, 11'h005);
      set_a(1, 1, 11'h005, 0, 4'h0); step();
      chk("t1_rack", a_ack_s, 1); chk("t1_rstrobe", rd_s, 1);
      set_a(0, 1, 0, 0, 0); step();
      chk("t1_rdata", rdata_s, 32'h12345678);

      // partial write by B
      set_b(1, 0, 11'h7ff, 32'hAABBCCDD, 4'hf); step(); chk("t2_pre_ack", b_ack_s, 1);
      set_b(1, 0, 11'h7ff, 32'h11223344, 4'b0101); step();
      chk("t2_rmw_read", rd_s, 1); chk("t2_rmw_noack", b_ack_s, 0);
      step();
      chk("t2_rmw_write", wr_s, 1); chk("t2_rmw_data", wd_s, 32'hAA22CC44);
      chk("t2_rmw_addr", addr_s, 11'h7ff); chk("t2_rmw_ack", b_ack_s, 1);
      set_b(1, 1, 11'h7ff, 0, 0); step(); chk("t2_rack", b_ack_s, 1);
      set_b(0, 1, 0, 0, 0); step(); chk("t2_rdata", rdata_s, 32'hAA22CC44);

      // A partial write contending with B read; B was last granted
      set_a(1, 0, 11'h7ff, 32'h99000000, 4'b1000);
      set_b(1, 1, 11'h005, 0, 0);
      step(); chk("t4_a_first", a_ack_s | b_ack_s, 0); chk("t4_rd_addr", addr_s, 11'h7ff);
      step(); chk("t4_a_ack", a_ack_s, 1); chk("t4_b_wait", b_ack_s, 0); chk("t4_merge", wd_s, 32'h9922CC44);
      set_a(0, 1, 0, 0, 0);
      step(); chk("t4_b_ack", b_ack_s, 1);
      set_b(0, 1, 0, 0, 0); step();

      // zero-enable write leaves contents alone
      set_a(1, 0, 11'h010, 32'hCAFEF00D, 4'hf); step();
      set_a(1, 0, 11'h010, 32'hFFFFFFFF, 4'h0); step();
      chk("t5_ack", a_ack_s, 1); chk("t5_nowrite", wr_s, 0); chk("t5_noread", rd_s, 0);
      set_a(1, 1, 11'h010, 0, 0); step();
      set_a(0, 1, 0, 0, 0); step(); chk("t5_rdata", rdata_s, 32'hCAFEF00D);
      step();

      // reset during MERGE
      set_a(1, 0, 11'h020, 32'h01020304, 4'hf); step();
      set_a(1, 0, 11'h020, 32'hFFFFFFFF, 4'b0011); step();
      chk("t6_rmw_read", rd_s, 1);
      rst_n = 0; #1;
      chk("t6_wr", sram_write, 0); chk("t6_rd", sram_read, 0); chk("t6_ack", a_ack, 0);
      chk("t6_addr", sram_address, 0); chk("t6_wd", sram_write_data, 0);
      set_a(0, 1, 0, 0, 0);
      step();
      rst_n = 1;
      set_a(1, 1, 11'h020, 0, 0);
      set_b(1, 1, 11'h005, 0, 0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("t3_alt_a", a_ack_s, (i % 2 == 0));
         chk("t3_alt_b", b_ack_s, (i % 2 == 1));
         if (i == 1) chk("t6_nowrite", rdata_s, 32'h01020304);
      end
      set_a(0, 1, 0, 0, 0); set_b(0, 1, 0, 0, 0); step();

      // randomized traffic
      pend_a = 0; pend_b = 0; wait_a = 0; wait_b = 0; max_a = 0; max_b = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!pend_a && $urandom_range(3, 0) != 0) begin
            pend_a = 1;
            set_a(1, $urandom_range(1, 0), 11'($urandom_range(15, 0)), $urandom, rand_be());
         end
         if (!pend_b && $urandom_range(3, 0) != 0) begin
            pend_b = 1;
            set_b(1, $urandom_range(1, 0), 11'($urandom_range(15, 0)), $urandom, rand_be());
         end
         a_req = pend_a; b_req = pend_b;
         step();
         if (pend_a) begin
            if (a_ack_s) begin pend_a = 0; wait_a = 0; end
            else begin wait_a++; if (wait_a > max_a) max_a = wait_a; end
         end
         if (pend_b) begin
            if (b_ack_s) begin pend_b = 0; wait_b = 0; end
            else begin wait_b++; if (wait_b > max_b) max_b = wait_b; end
         end
         a_req = pend_a; b_req = pend_b;
      end
      chk("max_wait_a_ok", (max_a <= 3), 1);
      chk("max_wait_b_ok", (max_b <= 3), 1);
      set_a(0, 1, 0, 0, 0); set_b(0, 1, 0, 0, 0);
      step(); step();

      // final sweep: SRAM contents against the reference
      for (int i = 0; i < 32; i++) chk("final_mem", sram_mem[i], ref_mem[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
